msg_schedule_gen: RTL and testbench



---
 rtl/msg_schedule_gen.sv | 178 +++++++++++++++++
 tb/tb_msg_schedule_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule_gen.sv
// msg_schedule_gen: SHA-2 message schedule generator.
// Takes one message block as 16 words over a ready/valid handshake and emits
// the schedule W0..W(ROUNDS-1), one registered word per cycle. Words 0..15
// pass straight through; words 16.. are expanded from a 16-word window.
// WORD_W=32/ROUNDS=64 covers SHA-224/256, WORD_W=64/ROUNDS=80 covers SHA-384/512.
// Optional macro MSG_SCHED_BACKPRESSURE_EN adds out_ready_i; without it the
// consumer is assumed always ready and the schedule free-runs.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   abort_i           synchronous clear back to IDLE, drops the current block
//   in_data_i/valid_i message word input (W0 first); in_ready_o handshake
//   wt_o, wt_idx_o    schedule word Wt and its round index t
//   wt_valid_o        wt_o / wt_idx_o valid
//   block_done_o      pulse on the beat carrying t=ROUNDS-1
//   out_ready_i       consumer ready (MSG_SCHED_BACKPRESSURE_EN only)
module msg_schedule_gen #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [WORD_W-1:0] wt_o,
  output logic              wt_valid_o,
  output logic [IDX_W-1:0]  wt_idx_o,
  output logic              block_done_o
`ifdef MSG_SCHED_BACKPRESSURE_EN
  ,
  input  logic              out_ready_i
`endif
);

  // Reject unsupported configurations at elaboration.
  if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
    $error("msg_schedule_gen: illegal WORD_W/ROUNDS pairing");
  end
  if (ROUNDS > (1 << IDX_W)) begin : g_bad_idx
    $error("msg_schedule_gen: IDX_W too narrow for ROUNDS");
  end

  localparam bit          IS64    = (WORD_W == 64);
  localparam int unsigned S0_R1   = IS64 ? 1  : 7;
  localparam int unsigned S0_R2   = IS64 ? 8  : 18;
  localparam int unsigned S0_SH   = IS64 ? 7  : 3;
  localparam int unsigned S1_R1   = IS64 ? 19 : 17;
  localparam int unsigned S1_R2   = IS64 ? 61 : 19;
  localparam int unsigned S1_SH   = IS64 ? 6  : 10;
  localparam logic [IDX_W-1:0] LOAD_LAST = IDX_W'(15);
  localparam logic [IDX_W-1:0] EXP_LAST  = IDX_W'(ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND} state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

  state_e                        state_q, state_d;
  logic [15:0][WORD_W-1:0]       win_q, win_d;    // [0] is the newest word
  logic [IDX_W-1:0]              cnt_q, cnt_d;
  logic [WORD_W-1:0]             wt_q, wt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          wt_valid_q, wt_valid_d;
  logic                          done_q, done_d;
  logic                          in_ready_q, in_ready_d;
  logic                          stall_c;
  logic [WORD_W-1:0]             exp_word_c;

  // A presented beat that the consumer has not taken freezes everything.
`ifdef MSG_SCHED_BACKPRESSURE_EN
  assign stall_c    = wt_valid_q & ~out_ready_i;
  assign in_ready_o = in_ready_q & ~stall_c;
`else
  assign stall_c    = 1'b0;
  assign in_ready_o = in_ready_q;
`endif

  // Wt = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], modulo 2^WORD_W.
  assign exp_word_c = sigma1(win_q[1]) + win_q[6] + sigma0(win_q[14]) + win_q[15];

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    wt_d       = wt_q;
    idx_d      = idx_q;
    wt_valid_d = wt_valid_q;
    done_d     = done_q;
    in_ready_d = in_ready_q;

    if (abort_i) begin
      state_d    = S_IDLE;
      win_d      = '0;
      cnt_d      = '0;
      wt_valid_d = 1'b0;
      done_d     = 1'b0;
      in_ready_d = 1'b1;
    end else if (!stall_c) begin
      wt_valid_d = 1'b0;
      done_d     = 1'b0;
      unique case (state_q)
        S_IDLE, S_LOAD: begin
          if (in_valid_i && in_ready_q) begin
            win_d      = {win_q[14:0], in_data_i};
            wt_d       = in_data_i;
            wt_valid_d = 1'b1;
            if (state_q == S_IDLE) begin
              idx_d   = '0;
              cnt_d   = IDX_W'(1);
              state_d = S_LOAD;
            end else begin
              idx_d   = cnt_q;
              cnt_d   = cnt_q + IDX_W'(1);
              state_d = (cnt_q == LOAD_LAST) ? S_EXPAND : S_LOAD;
            end
          end
        end
        S_EXPAND: begin
          win_d      = {win_q[14:0], exp_word_c};
          wt_d       = exp_word_c;
          idx_d      = cnt_q;
          wt_valid_d = 1'b1;
          if (cnt_q == EXP_LAST) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d != S_EXPAND);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      wt_q       <= '0;
      idx_q      <= '0;
      wt_valid_q <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      wt_q       <= wt_d;
      idx_q      <= idx_d;
      wt_valid_q <= wt_valid_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign wt_o         = wt_q;
  assign wt_idx_o     = idx_q;
  assign wt_valid_o   = wt_valid_q;
  assign block_done_o = done_q;

endmodule

// File: tb/tb_msg_schedule_gen.sv
// tb_msg_schedule_gen: directed self-checking bench for msg_schedule_gen.
// One SHA-256 instance (default parameters) and one SHA-512 instance.
module tb_msg_schedule_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] wt;
  logic        wt_valid;
  logic [6:0]  wt_idx;
  logic        block_done;
  logic        out_ready;

  logic        abort64;
  logic [63:0] in_data64;
  logic        in_valid64;
  logic        in_ready64;
  logic [63:0] wt64;
  logic        wt_valid64;
  logic [6:0]  wt_idx64;
  logic        block_done64;
  logic        out_ready64;

  int errors = 0;
  int checks = 0;

  logic [31:0] blk  [16];
  logic [31:0] gold [64];
  logic [31:0] hand [3];

  always #5 clk = ~clk;

  msg_schedule_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .abort_i      (abort),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .wt_o         (wt),
    .wt_valid_o   (wt_valid),
    .wt_idx_o     (wt_idx),
    .block_done_o (block_done)
`ifdef MSG_SCHED_BACKPRESSURE_EN
    ,
    .out_ready_i  (out_ready)
`endif
  );

  msg_schedule_gen #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut64 (
    .clk          (clk),
    .rst_n        (rst_n),
    .abort_i      (abort64),
    .in_data_i    (in_data64),
    .in_valid_i   (in_valid64),
    .in_ready_o   (in_ready64),
    .wt_o         (wt64),
    .wt_valid_o   (wt_valid64),
    .wt_idx_o     (wt_idx64),
    .block_done_o (block_done64)
`ifdef MSG_SCHED_BACKPRESSURE_EN
    ,
    .out_ready_i  (out_ready64)
`endif
  );

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams the "abc" block and checks every beat. gap_after/gap_len insert
  // idle input cycles, bp_at stalls the consumer for 4 cycles, stop_at
  // returns right after that beat is seen (block left in flight).
  task automatic stream_abc(input int gap_after, input int gap_len,
                            input int bp_at, input int stop_at, input string tag);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        in_valid = 1'b1;
        in_data  = blk[t];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      checks++;
      if (wt_valid !== 1'b1 || wt_idx !== 7'(t) || wt !== gold[t]) begin
        errors++;
        $display("FAIL %s beat t=%0d: got v=%b idx=%0d wt=%08h, expected v=1 idx=%0d wt=%08h",
                 tag, t, wt_valid, wt_idx, wt, t, gold[t]);
      end
      checks++;
      if (block_done !== (t == 63)) begin
        errors++;
        $display("FAIL %s block_done t=%0d: got %b expected %b", tag, t, block_done, (t == 63));
      end
      if (t >= 16 && t <= 18) begin
        checks++;
        if (wt !== hand[t-16]) begin
          errors++;
          $display("FAIL %s known W%0d: got %08h expected %08h", tag, t, wt, hand[t-16]);
        end
      end
      if (t == 20) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready in expand: got %b expected 0", tag, in_ready);
        end
      end
      if (t == gap_after) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          checks++;
          if (wt_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s gap cycle %0d: got wt_valid=%b expected 0", tag, g, wt_valid);
          end
        end
      end
      if (t == bp_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          tick();
          checks++;
          if (wt_valid !== 1'b1 || wt_idx !== 7'(t) || wt !== gold[t] || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s stall %0d: got v=%b idx=%0d wt=%08h rdy=%b, expected v=1 idx=%0d wt=%08h rdy=0",
                     tag, s, wt_valid, wt_idx, wt, in_ready, t, gold[t]);
          end
        end
        out_ready = 1'b1;
      end
      if (t == stop_at) return;
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    checks++;
    if (wt_valid !== 1'b0 || block_done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v=%b done=%b rdy=%b, expected v=0 done=0 rdy=1",
               tag, wt_valid, block_done, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wt !== 32'h0 || wt_valid !== 1'b0 || wt_idx !== 7'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL reset values: got wt=%08h v=%b idx=%0d done=%b, expected all 0",
               wt, wt_valid, wt_idx, block_done);
    end
    rst_n = 1'b1;
    tick();
    expect_idle("after reset");
  endtask

  task automatic test_abc();
    stream_abc(-1, 0, -1, -1, "abc");
    tick();
    expect_idle("abc end");
  endtask

  task automatic test_back_to_back();
    stream_abc(-1, 0, -1, -1, "b2b first");
    stream_abc(-1, 0, -1, -1, "b2b second");
    tick();
    expect_idle("b2b end");
  endtask

  task automatic test_gap();
    stream_abc(5, 3, -1, -1, "gap");
    tick();
    expect_idle("gap end");
  endtask

  task automatic test_abort();
    stream_abc(-1, 0, -1, 40, "pre-abort");
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    expect_idle("abort cycle");
    tick();
    expect_idle("after abort");
    stream_abc(-1, 0, -1, -1, "post-abort");
    tick();
  endtask

  task automatic test_reset_mid();
    stream_abc(-1, 0, -1, 20, "pre-reset");
    rst_n = 1'b0;
    #1;
    checks++;
    if (wt !== 32'h0 || wt_valid !== 1'b0 || wt_idx !== 7'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL async reset: got wt=%08h v=%b idx=%0d done=%b, expected all 0",
               wt, wt_valid, wt_idx, block_done);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("after mid reset");
    end
    stream_abc(-1, 0, -1, -1, "post-reset");
    tick();
  endtask

  task automatic test_zero64();
    int dones = 0;
    for (int t = 0; t < 80; t++) begin
      in_valid64 = (t < 16);
      in_data64  = 64'h0;
      tick();
      checks++;
      if (wt_valid64 !== 1'b1 || wt_idx64 !== 7'(t) || wt64 !== 64'h0) begin
        errors++;
        $display("FAIL zero64 beat t=%0d: got v=%b idx=%0d wt=%016h, expected v=1 idx=%0d wt=0",
                 t, wt_valid64, wt_idx64, wt64, t);
      end
      if (block_done64 === 1'b1) dones++;
    end
    checks++;
    if (block_done64 !== 1'b1 || dones != 1) begin
      errors++;
      $display("FAIL zero64 block_done: got last=%b count=%0d, expected last=1 count=1",
               block_done64, dones);
    end
    in_valid64 = 1'b0;
    tick();
    checks++;
    if (wt_valid64 !== 1'b0 || block_done64 !== 1'b0) begin
      errors++;
      $display("FAIL zero64 end: got v=%b done=%b, expected 0 0", wt_valid64, block_done64);
    end
  endtask

  task automatic test_backpressure();
    stream_abc(-1, 0, 30, -1, "backpressure");
    tick();
    expect_idle("backpressure end");
  endtask

  initial begin
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    abort64    = 1'b0;
    in_valid64 = 1'b0;
    in_data64  = '0;
    out_ready64 = 1'b1;

    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    hand[0] = 32'h61626380;
    hand[1] = 32'h000F0000;
    hand[2] = 32'h7DA86405;
    for (int i = 0; i < 16; i++) gold[i] = blk[i];
    for (int i = 16; i < 64; i++)
      gold[i] = bsig1(gold[i-2]) + gold[i-7] + bsig0(gold[i-15]) + gold[i-16];

    test_reset();
    test_abc();
    test_back_to_back();
    test_gap();
    test_abort();
    test_reset_mid();
    test_zero64();
`ifdef MSG_SCHED_BACKPRESSURE_EN
    test_backpressure();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
